// File: rtl/rd_vdma_pkg.sv
// Shared definitions for the VDMA read-path FIFO status controller:
// FSM state encoding and the default request watchdog limit.
package rd_vdma_pkg;

  localparam logic [23:0] TIMEOUT_DEFAULT = 24'hFFF000;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CHECK    = 4'd1,
    BREQ     = 4'd2,
    BWAIT    = 4'd3,
    BFSH     = 4'd4,
    TREQ     = 4'd5,
    TWAIT    = 4'd6,
    TFSH     = 4'd7,
    LINE_END = 4'd8,
    TERR     = 4'd9
  } rd_state_e;

  // True while a request is outstanding with the read master.
  function automatic logic is_req_phase(input rd_state_e st);
    return (st == BREQ) || (st == BWAIT) || (st == TREQ) || (st == TWAIT);
  endfunction

endpackage

// File: rtl/rd_burst_watchdog.sv
// Outstanding-request watchdog for rd_fifo_status_ctrl; only built when
// RD_FIFO_STATUS_TIMEOUT_EN is defined.
`ifdef RD_FIFO_STATUS_TIMEOUT_EN
module rd_burst_watchdog
  import rd_vdma_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic rst_n,
  input  logic run,
  output logic expired
);

  logic [23:0] cnt_r;

  // Counts clocks spent with a request outstanding; clears as soon as it resolves.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      cnt_r <= 24'd0;
    end else if (run) begin
      cnt_r <= cnt_r + 24'd1;
    end else begin
      cnt_r <= 24'd0;
    end
  end

  assign expired = run && (cnt_r == TIMEOUT);

endmodule
`endif

// File: rtl/rd_fifo_status_ctrl.sv
// Read-data FIFO status controller: issues full bursts and one tail burst per
// line while FIFO space allows. Optional watchdog: RD_FIFO_STATUS_TIMEOUT_EN.
module rd_fifo_status_ctrl
  import rd_vdma_pkg::*;
#(
  parameter int          DEPTH     = 512,
  parameter int          CSIZE     = 10,
  parameter int          BURST_LEN = 100,
  parameter int          LSIZE     = 9,
  parameter int          WSIZE     = 16,
  parameter logic [23:0] TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             line_start,
  input  logic [WSIZE-1:0] line_len,
  input  logic [CSIZE-1:0] count,
  input  logic             fifo_full,
  output logic             burst_req,
  output logic             tail_req,
  output logic [LSIZE-1:0] req_len,
  input  logic             resp,
  input  logic             done,
  output logic             burst_done,
  output logic             tail_done,
  output logic             line_done,
  output logic             line_overrun,
  output logic             rst_chain
);

  localparam int             CW      = (WSIZE > CSIZE + 1) ? WSIZE : CSIZE + 1;
  localparam logic [CSIZE:0] DEPTH_C = (CSIZE + 1)'(DEPTH);
  localparam logic [CW-1:0]  BURST_X = CW'(BURST_LEN);

  rd_state_e        state_r;
  rd_state_e        fsm_next_s;
  rd_state_e        nstate_s;
  logic [WSIZE-1:0] remaining_r;
  logic [CSIZE:0]   free_s;
  logic [CSIZE:0]   free_r;
  logic [CW-1:0]    rem_x_s;
  logic [CW-1:0]    free_x_s;
  logic             can_go_s;
  logic             timeout_s;
  logic             burst_req_r;
  logic             tail_req_r;
  logic [LSIZE-1:0] req_len_r;
  logic             burst_done_r;
  logic             tail_done_r;
  logic             line_done_r;
  logic             line_overrun_r;
  logic             rst_chain_r;

  // Free space, saturated at zero when count reports more than the FIFO holds.
  always_comb begin
    if ({1'b0, count} > DEPTH_C) begin
      free_s = {(CSIZE + 1){1'b0}};
    end else begin
      free_s = DEPTH_C - {1'b0, count};
    end
  end

  assign rem_x_s  = CW'(remaining_r);
  assign free_x_s = CW'(free_r);
  assign can_go_s = enable && !fifo_full;

`ifdef RD_FIFO_STATUS_TIMEOUT_EN
  rd_burst_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .rst_n   (rst_n),
    .run     (is_req_phase(state_r)),
    .expired (timeout_s)
  );
`else
  assign timeout_s = 1'b0 && (TIMEOUT != 24'd0);
`endif

  // Line sequencing: decide full burst, tail burst or line end from CHECK.
  always_comb begin
    fsm_next_s = state_r;
    case (state_r)
      IDLE:     if (line_start) fsm_next_s = CHECK; else fsm_next_s = IDLE;
      CHECK: begin
        if (remaining_r == {WSIZE{1'b0}}) begin
          fsm_next_s = LINE_END;
        end else if (can_go_s && rem_x_s >= BURST_X && free_x_s >= BURST_X) begin
          fsm_next_s = BREQ;
        end else if (can_go_s && rem_x_s < BURST_X && free_x_s >= rem_x_s) begin
          fsm_next_s = TREQ;
        end else begin
          fsm_next_s = CHECK;
        end
      end
      BREQ: begin
        if (resp && done)  fsm_next_s = BFSH;
        else if (resp)     fsm_next_s = BWAIT;
        else               fsm_next_s = BREQ;
      end
      BWAIT:    if (done) fsm_next_s = BFSH; else fsm_next_s = BWAIT;
      BFSH:     fsm_next_s = CHECK;
      TREQ: begin
        if (resp && done)  fsm_next_s = TFSH;
        else if (resp)     fsm_next_s = TWAIT;
        else               fsm_next_s = TREQ;
      end
      TWAIT:    if (done) fsm_next_s = TFSH; else fsm_next_s = TWAIT;
      TFSH:     fsm_next_s = CHECK;
      LINE_END: fsm_next_s = IDLE;
      TERR:     fsm_next_s = IDLE;
      default:  fsm_next_s = IDLE;
    endcase
  end

  // A stuck request overrides normal sequencing.
  always_comb begin
    if (timeout_s) begin
      nstate_s = TERR;
    end else begin
      nstate_s = fsm_next_s;
    end
  end

  // State, free-space snapshot and remaining-word bookkeeping.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      free_r      <= {(CSIZE + 1){1'b0}};
      remaining_r <= {WSIZE{1'b0}};
    end else begin
      state_r <= nstate_s;
      free_r  <= free_s;
      if (state_r == IDLE && line_start) begin
        remaining_r <= line_len;
      end else if (state_r == BFSH || state_r == TFSH) begin
        remaining_r <= remaining_r - WSIZE'(req_len_r);
      end else if (state_r == TERR) begin
        remaining_r <= {WSIZE{1'b0}};
      end else begin
        remaining_r <= remaining_r;
      end
    end
  end

  // Registered requests and status pulses; req_len holds between requests.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      burst_req_r    <= 1'b0;
      tail_req_r     <= 1'b0;
      req_len_r      <= {LSIZE{1'b0}};
      burst_done_r   <= 1'b0;
      tail_done_r    <= 1'b0;
      line_done_r    <= 1'b0;
      line_overrun_r <= 1'b0;
      rst_chain_r    <= 1'b0;
    end else begin
      burst_req_r    <= (nstate_s == BREQ);
      tail_req_r     <= (nstate_s == TREQ);
      if (nstate_s == BREQ) begin
        req_len_r <= LSIZE'(BURST_LEN);
      end else if (nstate_s == TREQ) begin
        req_len_r <= remaining_r[LSIZE-1:0];
      end else begin
        req_len_r <= req_len_r;
      end
      burst_done_r   <= (state_r == BFSH);
      tail_done_r    <= (state_r == TFSH);
      line_done_r    <= (state_r == LINE_END);
      line_overrun_r <= line_start && (state_r != IDLE);
      rst_chain_r    <= (nstate_s == TERR);
    end
  end

  assign burst_req    = burst_req_r;
  assign tail_req     = tail_req_r;
  assign req_len      = req_len_r;
  assign burst_done   = burst_done_r;
  assign tail_done    = tail_done_r;
  assign line_done    = line_done_r;
  assign line_overrun = line_overrun_r;
  assign rst_chain    = rst_chain_r;

endmodule

// File: tb/tb_rd_fifo_status_ctrl.sv
// Self-checking bench for rd_fifo_status_ctrl: table of whole lines checked
// through an event scoreboard, plus hand-written multi-cycle corner cases.
module tb_rd_fifo_status_ctrl;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        line_start;
  logic [15:0] line_len;
  logic [9:0]  count;
  logic        fifo_full;
  logic        burst_req;
  logic        tail_req;
  logic [8:0]  req_len;
  logic        resp;
  logic        done;
  logic        burst_done;
  logic        tail_done;
  logic        line_done;
  logic        line_overrun;
  logic        rst_chain;

  rd_fifo_status_ctrl #(
    .TIMEOUT (24'd16)
  ) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .enable       (enable),
    .line_start   (line_start),
    .line_len     (line_len),
    .count        (count),
    .fifo_full    (fifo_full),
    .burst_req    (burst_req),
    .tail_req     (tail_req),
    .req_len      (req_len),
    .resp         (resp),
    .done         (done),
    .burst_done   (burst_done),
    .tail_done    (tail_done),
    .line_done    (line_done),
    .line_overrun (line_overrun),
    .rst_chain    (rst_chain)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] len;
    logic [9:0]  cnt;
    int          n_full;
    int          tail;
  } line_vec_t;

  // kinds: 0 full request, 1 tail request, 2 burst_done, 3 tail_done, 4 line_done
  typedef struct {
    int kind;
    int len;
  } ev_t;

  line_vec_t tbl[6];
  ev_t       sb_q[$];
  int        n_vec = 0;
  int        n_err = 0;
  bit        sb_on = 1'b0;
  bit        auto_resp = 1'b0;
  bit        req_seen = 1'b0;
  bit        rc_allowed = 1'b0;
  bit        rc_bad = 1'b0;
  int        rsp_ph = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int len);
    ev_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_unexpected: got event kind %0d, expected none", kind);
    end else begin
      e = sb_q.pop_front();
      chk("sb_kind", kind, e.kind);
      if (kind < 2) chk("sb_req_len", len, e.len);
    end
  endtask

  // One clock: sample at the falling edge, then run monitor and responder.
  task automatic tick();
    @(negedge clock);
    if (rst_chain && !rc_allowed) rc_bad = 1'b1;
    if (sb_on) begin
      if (burst_req && tail_req) chk("req_exclusive", 32'd1, 32'd0);
      if ((burst_req || tail_req) && !req_seen) expect_ev(tail_req ? 1 : 0, int'(req_len));
      req_seen = burst_req || tail_req;
      if (burst_done) expect_ev(2, 0);
      if (tail_done)  expect_ev(3, 0);
      if (line_done)  expect_ev(4, 0);
    end
    if (auto_resp) begin
      resp = 1'b0;
      done = 1'b0;
      case (rsp_ph)
        0: if (burst_req || tail_req) rsp_ph = 1;
        1: begin resp = 1'b1; rsp_ph = 2; end
        2: rsp_ph = 3;
        3: begin done = 1'b1; rsp_ph = 0; end
        default: rsp_ph = 0;
      endcase
    end
  endtask

  task automatic start_line(input logic [15:0] len);
    line_start = 1'b1;
    line_len   = len;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    for (int c = 0; c < 20; c++) begin
      if (burst_req || tail_req) break;
      tick();
    end
    chk(nm, burst_req || tail_req, 1);
  endtask

  task automatic wait_line_done(input string nm, output logic extra_req);
    extra_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (burst_req || tail_req) extra_req = 1'b1;
      if (line_done) break;
    end
    chk(nm, line_done, 1);
  endtask

  initial begin
    logic xr;
    int   bd;

    tbl[0] = '{len: 16'd250, cnt: 10'd0,   n_full: 2, tail: 50};
    tbl[1] = '{len: 16'd100, cnt: 10'd0,   n_full: 1, tail: 0};
    tbl[2] = '{len: 16'd99,  cnt: 10'd0,   n_full: 0, tail: 99};
    tbl[3] = '{len: 16'd300, cnt: 10'd300, n_full: 3, tail: 0};
    tbl[4] = '{len: 16'd40,  cnt: 10'd450, n_full: 0, tail: 40};
    tbl[5] = '{len: 16'd1,   cnt: 10'd512, n_full: 0, tail: 0};
    tbl[5].cnt = 10'd511;
    tbl[5].tail = 1;

    rst_n = 1'b0; enable = 1'b1; line_start = 1'b0; line_len = 16'd0;
    count = 10'd0; fifo_full = 1'b0; resp = 1'b0; done = 1'b0;
    repeat (3) tick();
    chk("reset_flags", {burst_req, tail_req, burst_done, tail_done, line_done, line_overrun, rst_chain}, 0);
    chk("reset_req_len", req_len, 0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", {burst_req, tail_req, line_done}, 0);

    // Whole lines through the scoreboard with an automatic read master.
    sb_on = 1'b1;
    auto_resp = 1'b1;
    for (int i = 0; i < 6; i++) begin
      count = tbl[i].cnt;
      for (int f = 0; f < tbl[i].n_full; f++) begin
        sb_q.push_back('{kind: 0, len: 100});
        sb_q.push_back('{kind: 2, len: 0});
      end
      if (tbl[i].tail != 0) begin
        sb_q.push_back('{kind: 1, len: tbl[i].tail});
        sb_q.push_back('{kind: 3, len: 0});
      end
      sb_q.push_back('{kind: 4, len: 0});
      start_line(tbl[i].len);
      for (int c = 0; c < 3000; c++) begin
        if (sb_q.size() == 0) break;
        tick();
      end
      chk("line_complete", sb_q.size(), 0);
      sb_q.delete();
      repeat (3) tick();
    end
    sb_on = 1'b0;
    auto_resp = 1'b0;
    resp = 1'b0;
    done = 1'b0;
    tick();

    // Low free space: request waits for the count drop, then resp+done together.
    count = 10'd450;
    tick();
    start_line(16'd100);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("no_req_low_free", burst_req || tail_req, 0);
    end
    count = 10'd412;
    tick();
    chk("req_after_drop_1", burst_req, 0);
    tick();
    chk("req_after_drop_2", burst_req, 1);
    chk("req_len_full", req_len, 100);
    resp = 1'b1; done = 1'b1;
    tick();
    resp = 1'b0; done = 1'b0;
    chk("req_dropped", burst_req, 0);
    chk("bdone_early", burst_done, 0);
    tick();
    chk("bdone_pulse", burst_done, 1);
    tick();
    chk("bdone_one_cycle", burst_done, 0);
    wait_line_done("line_done_fast", xr);
    chk("no_extra_req_fast", xr, 0);

    // Count beyond DEPTH means no free space at all.
    count = 10'd700;
    start_line(16'd5);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("no_req_overfull", burst_req || tail_req, 0);
    end
    count = 10'd0;
    wait_req("tail_after_overfull");
    chk("tail_kind", tail_req, 1);
    chk("tail_len", req_len, 5);
    resp = 1'b1; done = 1'b1;
    tick();
    resp = 1'b0; done = 1'b0;
    wait_line_done("line_done_overfull", xr);

    // Zero-length line: line_done three cycles after line_start, no request.
    tick();
    line_start = 1'b1; line_len = 16'd0;
    tick();
    line_start = 1'b0;
    chk("zero_ld_c1", line_done, 0);
    tick();
    chk("zero_ld_c2", line_done, 0);
    tick();
    chk("zero_ld_c3", line_done, 1);
    chk("zero_no_req", burst_req || tail_req, 0);
    tick();
    chk("zero_ld_c4", line_done, 0);

    // line_start during BWAIT: overrun pulse, no reload.
    start_line(16'd100);
    wait_req("ovr_req");
    resp = 1'b1;
    tick();
    resp = 1'b0;
    line_start = 1'b1; line_len = 16'd5;
    tick();
    line_start = 1'b0;
    chk("overrun_pulse", line_overrun, 1);
    tick();
    chk("overrun_one_cycle", line_overrun, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    wait_line_done("ovr_line_done", xr);
    chk("ovr_no_reload", xr, 0);

    // enable dropped mid-burst: current burst finishes, next waits for enable.
    start_line(16'd200);
    wait_req("en_req1");
    resp = 1'b1;
    tick();
    resp = 1'b0;
    enable = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    bd = 0;
    xr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (burst_done) bd++;
      if (burst_req || tail_req) xr = 1'b1;
    end
    chk("en_burst_finished", bd, 1);
    chk("en_held_off", xr, 0);
    enable = 1'b1;
    wait_req("en_req2");
    chk("en_req2_full", burst_req, 1);
    resp = 1'b1; done = 1'b1;
    tick();
    resp = 1'b0; done = 1'b0;
    wait_line_done("en_line_done", xr);

`ifdef RD_FIFO_STATUS_TIMEOUT_EN
    // Request never accepted: watchdog aborts the line.
    tick();
    start_line(16'd100);
    wait_req("wd_req");
    rc_allowed = 1'b1;
    bd = 0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (burst_done) bd++;
      chk("wd_rst_chain", rst_chain, (k == 17) ? 1 : 0);
    end
    rc_allowed = 1'b0;
    chk("wd_no_bdone", bd, 0);
    line_start = 1'b1; line_len = 16'd0;
    tick();
    line_start = 1'b0;
    chk("wd_back_idle", line_overrun, 0);
    wait_line_done("wd_next_line", xr);
`endif

    chk("rst_chain_quiet", rc_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/rd_fifo_status_ctrl.md
Name: rd_fifo_status_ctrl

Overview:
Read-side counterpart of the VDMA write-path FIFO status controller. It watches free space in the read-data FIFO, which feeds video out, and issues full-length AXI read burst requests to the read master while space allows. It finishes each line with one short tail burst for the leftover words and pulses line_done. It sits between the read-data FIFO and the AXI read-address/data engine.

Parameters:
DEPTH, 512, FIFO capacity in words
CSIZE, 10, width of FIFO count
BURST_LEN, 100, full burst length in words; must be <= DEPTH
LSIZE, 9, width of req_len; must hold BURST_LEN
WSIZE, 16, width of line_len / remaining-word counter
TIMEOUT, 24'hFFF000, watchdog limit in clocks, used only with the macro

Ports:
clock  in  1  clock
rst_n  in  1  synchronous active-low reset
enable  in  1  allows new bursts to start
line_start  in  1  one-cycle pulse; load line_len
line_len  in  WSIZE  words to fetch for this line
count  in  CSIZE  current FIFO fill level
fifo_full  in  1  FIFO full flag
burst_req  out  1  full-burst request, level
tail_req  out  1  tail-burst request, level
req_len  out  LSIZE  length of the current request
resp  in  1  read master accepted the request
done  in  1  last beat of the burst was written into the FIFO
burst_done  out  1  one-cycle pulse, full burst complete
tail_done  out  1  one-cycle pulse, tail burst complete
line_done  out  1  one-cycle pulse, whole line fetched
line_overrun  out  1  one-cycle pulse, line_start arrived while busy
rst_chain  out  1  watchdog recovery pulse

Behaviour:
- Reset: every output is 0. The FSM goes to IDLE. remaining and the watchdog counter clear to 0.
- free = DEPTH - count, computed at CSIZE+1 bits. A count above DEPTH saturates free to 0.
- IDLE: on line_start, load remaining <= line_len and go to CHECK.
- CHECK:
  - remaining == 0 -> LINE_END.
  - enable && !fifo_full && remaining >= BURST_LEN && free >= BURST_LEN -> BREQ.
  - enable && !fifo_full && 0 < remaining < BURST_LEN && free >= remaining -> TREQ.
  - Otherwise stay in CHECK.
- BREQ/TREQ:
  - burst_req/tail_req and req_len are registered from nstate. The request asserts the cycle after CHECK decides and holds until resp is sampled high.
  - resp -> BWAIT/TWAIT.
  - resp && done in the same cycle -> BFSH/TFSH directly.
- BWAIT/TWAIT: done -> BFSH/TFSH.
- BFSH/TFSH:
  - remaining <= remaining - req_len.
  - burst_done/tail_done pulses for one cycle.
  - Next state CHECK.
- LINE_END: line_done pulses for one cycle, then IDLE.
- line_len == 0: go IDLE -> CHECK -> LINE_END. line_done fires 3 cycles after line_start and no request is issued.
- line_start while not in IDLE: ignored; line_overrun pulses; remaining is unchanged.
- enable is sampled only in CHECK. Deasserting it mid-burst lets the current burst complete.
- done outside the WAIT states (or outside REQ together with resp) is ignored.
- req_len keeps its last value outside requests.
- rst_chain is 0 unless the optional feature is compiled in.

Optional Feature:
RD_FIFO_STATUS_TIMEOUT_EN.
- Defined:
  - A 24-bit counter runs in BREQ/BWAIT/TREQ/TWAIT and clears in every other state.
  - Reaching TIMEOUT sends the FSM to TERR, which pulses rst_chain for one cycle, clears remaining and goes to IDLE.
  - No done pulse is generated for the aborted burst.
- Undefined: no counter or TERR state; rst_chain is tied to 0.

Decomposition:
- Shared package rd_vdma_pkg holds:
  - the FSM state enum: IDLE, CHECK, BREQ, BWAIT, BFSH, TREQ, TWAIT, TFSH, LINE_END, TERR;
  - the default TIMEOUT constant.
- One natural sub-module: rd_burst_watchdog, holding the timeout counter and compare. It is instantiated only under the macro.

Test Plan:
- line_len=250, count=0: burst_req with req_len=100 twice, then tail_req with req_len=50. Expect burst_done x2, tail_done x1, line_done x1, and remaining ends at 0.
- count=450 (free 62), line_len=100: no request until count <= 412; burst_req appears exactly 2 cycles after the count drop.
- resp and done high in the same cycle as burst_req: go BFSH directly; burst_done pulses 1 cycle later.
- line_len=0: line_done pulses 3 cycles after line_start and no request is issued. A second line_start during BWAIT gives line_overrun=1 and no reload.
- enable dropped during BWAIT: the burst completes (burst_done). No new burst starts until enable returns.
- With the macro and TIMEOUT=16, resp is never asserted: rst_chain pulses 17 cycles into BREQ, the FSM returns to IDLE, and no burst_done occurs.
